// File: rtl/fir_coeff_loader.sv
// Streams FIR tap coefficients into a shadow bank and commits them to the active bank in one cycle.
// Optional build macro: COEF_CHECKSUM_EN adds a checksum trailer word that must match before commit.
module fir_coeff_loader #(
    parameter int TAPS     = 401,
    parameter int COEFBITS = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_start,
    input  logic                coef_valid,
    input  logic [COEFBITS-1:0] coef_data,
    output logic                coef_ready,
    output logic [COEFBITS-1:0] weights_out [0:TAPS-1],
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int IDXW = $clog2(TAPS + 1);
`ifdef COEF_CHECKSUM_EN
    localparam int NWORDS = TAPS + 1;
`else
    localparam int NWORDS = TAPS;
`endif
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NWORDS - 1);
    localparam logic [IDXW-1:0] TAPS_IDX = IDXW'(TAPS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_nx_s;
    logic [IDXW-1:0]     idx_r;
    logic                coef_ready_r;
    logic                busy_r;
    logic                done_r;
    logic                err_r;
    logic                accept_s;
    logic                last_s;
    logic                restart_s;
    logic                chk_ok_s;
    logic [COEFBITS-1:0] shadow_r [0:TAPS-1];
    logic [COEFBITS-1:0] active_r [0:TAPS-1];

`ifdef COEF_CHECKSUM_EN
    logic [COEFBITS-1:0] sum_r;

    function automatic logic [COEFBITS-1:0] csum_add(input logic [COEFBITS-1:0] acc,
                                                    input logic [COEFBITS-1:0] word);
        return acc + word;
    endfunction
`endif

    // Handshake qualification; load_start outside COMMIT always restarts
    always_comb begin
        accept_s  = (state_r == LOAD) && coef_valid && coef_ready_r;
        last_s    = accept_s && (idx_r == LAST_IDX);
        restart_s = load_start && (state_r != COMMIT);
`ifdef COEF_CHECKSUM_EN
        chk_ok_s  = (coef_data == sum_r);
`else
        chk_ok_s  = 1'b1;
`endif
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (load_start) begin
                    state_nx_s = LOAD;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            LOAD: begin
                if (load_start) begin
                    state_nx_s = LOAD;
                end else if (last_s) begin
                    state_nx_s = chk_ok_s ? COMMIT : IDLE;
                end else begin
                    state_nx_s = LOAD;
                end
            end
            COMMIT:  state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // Index, handshake and status registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_r        <= {IDXW{1'b0}};
            coef_ready_r <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            coef_ready_r <= (state_nx_s == LOAD);
            busy_r       <= (state_nx_s != IDLE);
            done_r       <= (state_r == COMMIT);
            if (restart_s) begin
                idx_r <= {IDXW{1'b0}};
                err_r <= 1'b0;
            end else if (last_s) begin
                idx_r <= {IDXW{1'b0}};
                err_r <= err_r | ~chk_ok_s;
            end else if (accept_s) begin
                idx_r <= idx_r + {{(IDXW-1){1'b0}}, 1'b1};
            end else begin
                idx_r <= idx_r;
            end
        end
    end

    // Shadow bank capture; the trailer word (idx == TAPS) is never stored
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TAPS; i++) begin
                shadow_r[i] <= {COEFBITS{1'b0}};
            end
        end else if (accept_s && !load_start && (idx_r < TAPS_IDX)) begin
            shadow_r[idx_r] <= coef_data;
        end
    end

    // Active bank: single-cycle copy of the whole shadow bank on commit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TAPS; i++) begin
                active_r[i] <= {COEFBITS{1'b0}};
            end
        end else if (state_r == COMMIT) begin
            active_r <= shadow_r;
        end
    end

`ifdef COEF_CHECKSUM_EN
    // Running modular sum of the coefficient words of the current load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_r <= {COEFBITS{1'b0}};
        end else if (restart_s) begin
            sum_r <= {COEFBITS{1'b0}};
        end else if (accept_s && (idx_r < TAPS_IDX)) begin
            sum_r <= csum_add(sum_r, coef_data);
        end
    end
`endif

    assign coef_ready  = coef_ready_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign err         = err_r;
    assign weights_out = active_r;

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Scoreboard bench for fir_coeff_loader: each issued full load queues its expected bank,
// a negedge monitor pops and compares on every done pulse.
module tb_fir_coeff_loader;
    localparam int TAPS = 401;
    localparam int CB   = 16;

    typedef logic [TAPS*CB-1:0] bank_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_start;
    logic          coef_valid;
    logic [CB-1:0] coef_data;
    logic          coef_ready;
    logic [CB-1:0] weights_out [0:TAPS-1];
    logic          busy;
    logic          done;
    logic          err;

    int    total = 0;
    int    bad   = 0;
    bank_t exp_q[$];
    bank_t cur_bank;
    bit    prev_done = 1'b0;

    fir_coeff_loader #(.TAPS(TAPS), .COEFBITS(CB)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .coef_valid (coef_valid),
        .coef_data  (coef_data),
        .coef_ready (coef_ready),
        .weights_out(weights_out),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    function automatic logic [CB-1:0] pat(input int mode, input logic [CB-1:0] cval, input int k);
        return (mode == 0) ? CB'(k) : cval;
    endfunction

    function automatic bank_t make_bank(input int mode, input logic [CB-1:0] cval);
        bank_t b;
        for (int k = 0; k < TAPS; k++) b[k*CB +: CB] = pat(mode, cval, k);
        return b;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic check_bank(input string name, input bank_t b);
        int n = 0;
        int first = -1;
        for (int k = 0; k < TAPS; k++) begin
            if (weights_out[k] !== b[k*CB +: CB]) begin
                n++;
                if (first < 0) first = k;
            end
        end
        total++;
        if (n != 0) begin
            bad++;
            $display("FAIL %s taps_wrong=%0d tap%0d actual=%h required=%h", name, n, first,
                     weights_out[first], b[first*CB +: CB]);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expected bank
    always @(negedge clk) begin
        if (rst) begin
            prev_done = 1'b0;
        end else begin
            if (prev_done) check("done_width", 32'(done), 32'd0);
            if (done) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done actual=1 required=0");
                end else begin
                    check_bank("commit_bank", exp_q.pop_front());
                    check("ready_at_done", 32'(coef_ready), 32'd0);
                    check("busy_at_done", 32'(busy), 32'd0);
                end
            end
            prev_done = done;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic send_words(input int n, input int mode, input logic [CB-1:0] cval,
                              input logic [CB-1:0] trailer, input bit gaps);
        int k   = 0;
        int cyc = 0;
        bit v;
        bit rdy;
        while (k < n && cyc < 20000) begin
            v          = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            coef_valid = v;
            coef_data  = (k >= TAPS) ? trailer : pat(mode, cval, k);
            rdy        = coef_ready;
            tick();
            if (v && rdy) k++;
            cyc++;
        end
        coef_valid = 1'b0;
        if (k < n) begin
            total++;
            bad++;
            $display("FAIL send_timeout accepted=%0d required=%0d", k, n);
        end
    endtask

    // Full load; returns just after the last handshake edge (FSM in COMMIT if accepted)
    task automatic do_load(input int mode, input logic [CB-1:0] cval, input bit gaps,
                           input bit good, input bit start);
        logic [CB-1:0] sum = '0;
        int            n   = TAPS;
        for (int k = 0; k < TAPS; k++) sum = sum + pat(mode, cval, k);
`ifdef COEF_CHECKSUM_EN
        n = TAPS + 1;
        if (!good) sum = sum - 16'd1;
`endif
        if (start) pulse_start();
        if (good) exp_q.push_back(make_bank(mode, cval));
        send_words(n, mode, cval, sum, gaps);
        check("no_early_done", 32'(done), 32'd0);
        check_bank("hold_until_commit", cur_bank);
    endtask

    initial begin
        rst        = 1'b1;
        load_start = 1'b0;
        coef_valid = 1'b0;
        coef_data  = '0;
        cur_bank   = '0;
        repeat (3) tick();
        check_bank("reset_weights", '0);
        check("reset_ready", 32'(coef_ready), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_err", 32'(err), 32'd0);
        rst = 1'b0;
        tick();

        // Ramp load, then load_start during COMMIT must be ignored
        do_load(0, 16'h0000, 1'b0, 1'b1, 1'b1);
        check("commit_state_busy", 32'(busy), 32'd1);
        pulse_start();
        repeat (3) tick();
        check("start_in_commit_ignored", 32'(busy), 32'd0);
        check("idle_ready", 32'(coef_ready), 32'd0);
        cur_bank = make_bank(0, 16'h0000);

        do_load(1, 16'h0005, 1'b0, 1'b1, 1'b1);
        repeat (3) tick();
        cur_bank = make_bank(1, 16'h0005);

        // Ramp load with random valid gaps over a bank of 5s
        do_load(0, 16'h0000, 1'b1, 1'b1, 1'b1);
        repeat (3) tick();
        cur_bank = make_bank(0, 16'h0000);
        check_bank("hold_after_commit", cur_bank);

        // Abort after 200 FFFF words; restart coincides with an offered FFFF word
        pulse_start();
        send_words(200, 1, 16'hFFFF, 16'h0000, 1'b0);
        load_start = 1'b1;
        coef_valid = 1'b1;
        coef_data  = 16'hFFFF;
        tick();
        load_start = 1'b0;
        coef_valid = 1'b0;
        check("busy_after_restart", 32'(busy), 32'd1);
        do_load(1, 16'h0001, 1'b0, 1'b1, 1'b0);
        repeat (3) tick();
        cur_bank = make_bank(1, 16'h0001);

        // Reset in the middle of a load over a bank of 5s
        do_load(1, 16'h0005, 1'b0, 1'b1, 1'b1);
        repeat (3) tick();
        cur_bank = make_bank(1, 16'h0005);
        pulse_start();
        send_words(150, 1, 16'h0007, 16'h0000, 1'b0);
        rst = 1'b1;
        tick();
        tick();
        check_bank("midload_rst_weights", '0);
        check("midload_rst_busy", 32'(busy), 32'd0);
        check("midload_rst_ready", 32'(coef_ready), 32'd0);
        rst = 1'b0;
        tick();
        cur_bank = '0;
        do_load(1, 16'h00A5, 1'b0, 1'b1, 1'b1);
        repeat (3) tick();
        cur_bank = make_bank(1, 16'h00A5);

`ifdef COEF_CHECKSUM_EN
        do_load(1, 16'h0001, 1'b0, 1'b1, 1'b1);
        repeat (3) tick();
        cur_bank = make_bank(1, 16'h0001);
        check("csum_ok_err", 32'(err), 32'd0);
        do_load(1, 16'h0001, 1'b0, 1'b0, 1'b1);
        repeat (3) tick();
        check("csum_bad_err", 32'(err), 32'd1);
        check("csum_bad_busy", 32'(busy), 32'd0);
        check_bank("csum_bad_hold", cur_bank);
        pulse_start();
        check("err_cleared_by_start", 32'(err), 32'd0);
`else
        check("err_never_set", 32'(err), 32'd0);
`endif

        repeat (5) tick();
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
